// File: rtl/wm_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : wm_phase_timer
// Purpose  : Phase timing, sensor debouncing and fill watchdog feeding the
//            washer controller FSM.
// Revision : 1.0 - initial release
// ============================================================================
module wm_phase_timer #(
    parameter int TICK_DIV          = 1000,
    parameter int SOAK_SECS         = 120,
    parameter int WASH_SECS         = 600,
    parameter int RINSE_SECS        = 300,
    parameter int SPIN_SECS         = 240,
    parameter int FILL_TIMEOUT_SECS = 90,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int CNT_W             = 12
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             soak_Operation,
    input  logic             wash_Operation,
    input  logic             rinse_Operation,
    input  logic             spin_Operation,
    input  logic             water_Intake,
    input  logic             cancel,
    input  logic             level_sensor,
    input  logic             temp_sensor,
    output logic             fill_Water,
    output logic             heat_Water,
    output logic             wash,
    output logic             timer_Fault,
    output logic [CNT_W-1:0] seconds_Left
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    logic [1:0] raw_sense;
    logic [1:0] sensed;

    assign raw_sense = {temp_sensor, level_sensor};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sensor
            logic            sync1_q, sync1_d;
            logic            sync2_q, sync2_d;
            logic            out_q, out_d;
            logic [DB_W-1:0] cnt_q, cnt_d;

            // Output flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
            always_comb begin
                sync1_d = raw_sense[gi];
                sync2_d = sync1_q;
                out_d   = out_q;
                cnt_d   = '0;
                if (sync2_q != out_q) begin
                    if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        out_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    out_q   <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    out_q   <= out_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign sensed[gi] = out_q;
        end
    endgenerate

    assign fill_Water = sensed[0];
    assign heat_Water = sensed[1];

    // Fill watchdog: free-running second prescaler, independent of phase timing.
    logic [PRE_W-1:0] wd_pre_q, wd_pre_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             wd_tick, wd_cond, wd_fire;

    assign wd_tick = (wd_pre_q == PRE_W'(TICK_DIV - 1));
    assign wd_cond = water_Intake && !fill_Water;
    assign wd_fire = wd_cond && wd_tick && (wd_cnt_q == CNT_W'(FILL_TIMEOUT_SECS - 1));

    always_comb begin
        wd_pre_d = wd_tick ? '0 : (wd_pre_q + 1'b1);
        wd_cnt_d = wd_cnt_q;
        if (cancel || !wd_cond) begin
            wd_cnt_d = '0;
        end else if (wd_tick && (wd_cnt_q != CNT_W'(FILL_TIMEOUT_SECS))) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    logic [3:0]       ops;
    logic             one_op, multi_op;
    logic [CNT_W-1:0] phase_secs;

    assign ops      = {soak_Operation, wash_Operation, rinse_Operation, spin_Operation};
    assign one_op   = $onehot(ops);
    assign multi_op = ($countones(ops) > 1);

    always_comb begin
        phase_secs = '0;
        case (ops)
            4'b1000: phase_secs = CNT_W'(SOAK_SECS);
            4'b0100: phase_secs = CNT_W'(WASH_SECS);
            4'b0010: phase_secs = CNT_W'(RINSE_SECS);
            4'b0001: phase_secs = CNT_W'(SPIN_SECS);
            default: phase_secs = '0;
        endcase
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] secs_q, secs_d;
    logic [PRE_W-1:0] ph_pre_q, ph_pre_d;
    logic [3:0]       phase_q, phase_d;
    logic             wash_q, wash_d;
    logic             fault_q, fault_d;

    // Priority: cancel, then any fault condition, then per-state behaviour.
    always_comb begin
        state_d  = state_q;
        secs_d   = secs_q;
        ph_pre_d = ph_pre_q;
        phase_d  = phase_q;
        wash_d   = 1'b0;
        fault_d  = fault_q;
        if (cancel) begin
            state_d  = S_IDLE;
            secs_d   = '0;
            ph_pre_d = '0;
            phase_d  = '0;
            fault_d  = 1'b0;
        end else if (wd_fire || multi_op) begin
            state_d  = S_FAULT;
            secs_d   = '0;
            ph_pre_d = '0;
            fault_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (one_op) begin
                        state_d  = S_RUN;
                        secs_d   = phase_secs;
                        ph_pre_d = '0;
                        phase_d  = ops;
                    end
                end
                S_RUN: begin
                    if ((ops & phase_q) == 4'b0000) begin
                        state_d  = S_IDLE;
                        secs_d   = '0;
                        ph_pre_d = '0;
                    end else if (ph_pre_q == PRE_W'(TICK_DIV - 1)) begin
                        ph_pre_d = '0;
                        if (secs_q != '0) begin
                            secs_d = secs_q - 1'b1;
                            if (secs_q == CNT_W'(1)) begin
                                wash_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                    end else begin
                        ph_pre_d = ph_pre_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (ops == 4'b0000) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    secs_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            secs_q   <= '0;
            ph_pre_q <= '0;
            phase_q  <= '0;
            wash_q   <= 1'b0;
            fault_q  <= 1'b0;
            wd_pre_q <= '0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            secs_q   <= secs_d;
            ph_pre_q <= ph_pre_d;
            phase_q  <= phase_d;
            wash_q   <= wash_d;
            fault_q  <= fault_d;
            wd_pre_q <= wd_pre_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign wash         = wash_q;
    assign timer_Fault  = fault_q;
    assign seconds_Left = secs_q;

endmodule
`default_nettype wire

// File: tb/tb_wm_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wm_phase_timer
// Purpose  : Self-checking bench for wm_phase_timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wm_phase_timer;

    localparam int T     = 4;
    localparam int SOAK  = 3;
    localparam int WASHS = 5;
    localparam int RINSE = 2;
    localparam int SPIN  = 4;
    localparam int FTO   = 5;
    localparam int DB    = 4;
    localparam int CW    = 12;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic soak_Operation = 1'b0, wash_Operation = 1'b0, rinse_Operation = 1'b0, spin_Operation = 1'b0;
    logic water_Intake = 1'b0, cancel = 1'b0, level_sensor = 1'b0, temp_sensor = 1'b0;
    logic fill_Water, heat_Water, wash, timer_Fault;
    logic [CW-1:0] seconds_Left;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    wm_phase_timer #(
        .TICK_DIV(T), .SOAK_SECS(SOAK), .WASH_SECS(WASHS), .RINSE_SECS(RINSE),
        .SPIN_SECS(SPIN), .FILL_TIMEOUT_SECS(FTO), .DEBOUNCE_CYCLES(DB), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .soak_Operation(soak_Operation), .wash_Operation(wash_Operation),
        .rinse_Operation(rinse_Operation), .spin_Operation(spin_Operation),
        .water_Intake(water_Intake), .cancel(cancel),
        .level_sensor(level_sensor), .temp_sensor(temp_sensor),
        .fill_Water(fill_Water), .heat_Water(heat_Water), .wash(wash),
        .timer_Fault(timer_Fault), .seconds_Left(seconds_Left)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_ops(input logic [3:0] o);
        {soak_Operation, wash_Operation, rinse_Operation, spin_Operation} = o;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic int secs_of(input logic [3:0] o);
        case (o)
            4'b1000: return SOAK;
            4'b0100: return WASHS;
            4'b0010: return RINSE;
            4'b0001: return SPIN;
            default: return 0;
        endcase
    endfunction

    task automatic do_reset();
        set_ops(4'b0000);
        cancel = 1'b0; water_Intake = 1'b0; level_sensor = 1'b0; temp_sensor = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_secs", int'(seconds_Left), 0);
        check("rst_wash", int'(wash), 0);
        check("rst_fault", int'(timer_Fault), 0);
        check("rst_fill", int'(fill_Water), 0);
        check("rst_heat", int'(heat_Water), 0);
        reset_n = 1'b1;
    endtask

    // Behavioural reference: sensors as a sliding window of raw samples, phase
    // timing as elapsed-cycle arithmetic from the start edge.
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_FAULT = 3;
    int         k, n_samp, m_state, m_start, m_n, m_wd, m_secs;
    logic [3:0] m_phase;
    bit         m_out[2];
    bit         hist[2][DB+2];
    bit         m_wash, m_fault;

    task automatic model_init();
        k = 0; n_samp = 0; m_state = M_IDLE; m_start = 0; m_n = 0; m_wd = 0; m_secs = 0;
        m_phase = 4'b0000; m_wash = 1'b0; m_fault = 1'b0;
        for (int s = 0; s < 2; s++) begin
            m_out[s] = 1'b0;
            for (int i = 0; i < DB + 2; i++) hist[s][i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit         old_fill, all_diff, wd_fire, wd_cond;
        logic [3:0] o;
        int         nops;
        k++;
        old_fill = m_out[0];
        for (int s = 0; s < 2; s++) begin
            for (int i = DB + 1; i > 0; i--) hist[s][i] = hist[s][i-1];
        end
        hist[0][0] = level_sensor;
        hist[1][0] = temp_sensor;
        if (n_samp < DB + 2) n_samp++;
        // hist[s][i] is the raw value seen at edge k-i; the output lags by two sync stages.
        for (int s = 0; s < 2; s++) begin
            if (n_samp == DB + 2) begin
                all_diff = 1'b1;
                for (int i = 2; i <= DB + 1; i++) if (hist[s][i] == m_out[s]) all_diff = 1'b0;
                if (all_diff) m_out[s] = !m_out[s];
            end
        end
        wd_cond = water_Intake && !old_fill;
        wd_fire = 1'b0;
        if (cancel || !wd_cond) m_wd = 0;
        else if (k % T == 0) begin
            m_wd++;
            if (m_wd == FTO) wd_fire = 1'b1;
        end
        o    = {soak_Operation, wash_Operation, rinse_Operation, spin_Operation};
        nops = $countones(o);
        m_wash = 1'b0;
        if (cancel) begin
            m_state = M_IDLE; m_fault = 1'b0;
        end else if (wd_fire || nops > 1) begin
            m_state = M_FAULT; m_fault = 1'b1;
        end else begin
            case (m_state)
                M_IDLE: if (nops == 1) begin
                    m_state = M_RUN; m_start = k; m_phase = o; m_n = secs_of(o);
                end
                M_RUN: begin
                    if ((o & m_phase) == 4'b0000) m_state = M_IDLE;
                    else if (k - m_start == m_n * T) begin
                        m_state = M_DONE; m_wash = 1'b1;
                    end
                end
                M_DONE: if (o == 4'b0000) m_state = M_IDLE;
                default: ;
            endcase
        end
        m_secs = (m_state == M_RUN) ? (m_n - (k - m_start) / T) : 0;
    endtask

    typedef struct {
        logic [3:0] ops;
        logic       exp_fault;
        int         exp_secs;
    } vec_t;

    initial begin
        vec_t vt[7];
        int   fire;
        vt[0] = '{4'b1000, 1'b0, SOAK};
        vt[1] = '{4'b0100, 1'b0, WASHS};
        vt[2] = '{4'b0010, 1'b0, RINSE};
        vt[3] = '{4'b0001, 1'b0, SPIN};
        vt[4] = '{4'b0110, 1'b1, 0};
        vt[5] = '{4'b1001, 1'b1, 0};
        vt[6] = '{4'b1111, 1'b1, 0};

        // Phase start/countdown/pulse per op pattern, plus illegal multi-op starts.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            set_ops(vt[v].ops);
            step();
            check($sformatf("v%0d_secs_start", v), int'(seconds_Left), vt[v].exp_secs);
            check($sformatf("v%0d_fault_start", v), int'(timer_Fault), int'(vt[v].exp_fault));
            if (!vt[v].exp_fault) begin
                for (int c = 1; c <= vt[v].exp_secs * T; c++) begin
                    step();
                    check($sformatf("v%0d_secs_c%0d", v, c), int'(seconds_Left), vt[v].exp_secs - c / T);
                    check($sformatf("v%0d_wash_c%0d", v, c), int'(wash), (c == vt[v].exp_secs * T) ? 1 : 0);
                end
                repeat (3) begin
                    step();
                    check($sformatf("v%0d_done_wash", v), int'(wash), 0);
                    check($sformatf("v%0d_done_secs", v), int'(seconds_Left), 0);
                end
                set_ops(4'b0000);
                step();
                set_ops(vt[v].ops);
                step();
                check($sformatf("v%0d_restart", v), int'(seconds_Left), vt[v].exp_secs);
            end else begin
                repeat (30) begin
                    step();
                    check($sformatf("v%0d_fault_wash", v), int'(wash), 0);
                    check($sformatf("v%0d_fault_hold", v), int'(timer_Fault), 1);
                end
                set_ops(4'b0000);
                step();
                set_ops(4'b1000);
                step();
                check($sformatf("v%0d_stuck_secs", v), int'(seconds_Left), 0);
                check($sformatf("v%0d_stuck_fault", v), int'(timer_Fault), 1);
                cancel = 1'b1;
                step();
                cancel = 1'b0;
                check($sformatf("v%0d_cancel_fault", v), int'(timer_Fault), 0);
                check($sformatf("v%0d_cancel_secs", v), int'(seconds_Left), 0);
                step();
                check($sformatf("v%0d_post_cancel_run", v), int'(seconds_Left), SOAK);
            end
        end

        // Debounce: short pulse ignored, long level passes after 2+DB edges, both directions.
        do_reset();
        level_sensor = 1'b1;
        repeat (3) begin step(); check("db_short_fill", int'(fill_Water), 0); end
        level_sensor = 1'b0;
        repeat (10) begin step(); check("db_short_fill_after", int'(fill_Water), 0); end
        level_sensor = 1'b1; temp_sensor = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            check($sformatf("db_rise_fill_c%0d", c), int'(fill_Water), (c >= 6) ? 1 : 0);
            check($sformatf("db_rise_heat_c%0d", c), int'(heat_Water), (c >= 6) ? 1 : 0);
        end
        level_sensor = 1'b0; temp_sensor = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            check($sformatf("db_fall_fill_c%0d", c), int'(fill_Water), (c < 6) ? 1 : 0);
            check($sformatf("db_fall_heat_c%0d", c), int'(heat_Water), (c < 6) ? 1 : 0);
        end

        // Fill watchdog fires within its one-tick window, then cancel recovers to IDLE.
        do_reset();
        water_Intake = 1'b1;
        fire = 0;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (fire == 0 && timer_Fault === 1'b1) fire = c;
        end
        n_cmp++;
        if (fire < 17 || fire > 20) begin
            n_fail++;
            $display("FAIL wd_window: fired at cycle %0d, required 17..20", fire);
        end
        set_ops(4'b1000);
        step();
        check("wd_fault_no_start", int'(seconds_Left), 0);
        cancel = 1'b1; water_Intake = 1'b0;
        step();
        cancel = 1'b0;
        check("wd_cancel_fault", int'(timer_Fault), 0);
        step();
        check("wd_cancel_idle_run", int'(seconds_Left), SOAK);

        // Watchdog held off while the tank reads full.
        do_reset();
        level_sensor = 1'b1;
        repeat (8) step();
        water_Intake = 1'b1;
        repeat (30) step();
        check("wd_full_no_fault", int'(timer_Fault), 0);
        level_sensor = 1'b0;
        repeat (30) step();
        check("wd_empty_fault", int'(timer_Fault), 1);

        // Cancel coincident with the final tick of a 2-second rinse.
        do_reset();
        set_ops(4'b0010);
        step();
        repeat (2 * T - 1) step();
        check("cx_secs_before", int'(seconds_Left), 1);
        cancel = 1'b1;
        step();
        check("cx_wash", int'(wash), 0);
        check("cx_secs", int'(seconds_Left), 0);
        cancel = 1'b0;
        step();
        check("cx_wash_next", int'(wash), 0);
        check("cx_idle_restart", int'(seconds_Left), RINSE);

        // Second op rising on the final tick: fault wins, no pulse.
        do_reset();
        set_ops(4'b0010);
        step();
        repeat (2 * T - 1) step();
        set_ops(4'b0110);
        step();
        check("sim_wash", int'(wash), 0);
        check("sim_fault", int'(timer_Fault), 1);
        check("sim_secs", int'(seconds_Left), 0);
        step();
        check("sim_wash_next", int'(wash), 0);

        // Asynchronous reset mid-phase.
        do_reset();
        level_sensor = 1'b1;
        repeat (8) step();
        check("ar_fill_pre", int'(fill_Water), 1);
        set_ops(4'b1000);
        step();
        repeat (T) step();
        check("ar_secs_pre", int'(seconds_Left), 2);
        #2 reset_n = 1'b0;
        #1;
        check("ar_secs", int'(seconds_Left), 0);
        check("ar_fill", int'(fill_Water), 0);
        check("ar_wash", int'(wash), 0);
        check("ar_fault", int'(timer_Fault), 0);
        set_ops(4'b0000); level_sensor = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (16) begin
            step();
            check("ar_post_wash", int'(wash), 0);
            check("ar_post_secs", int'(seconds_Left), 0);
        end

        // Randomized run against the behavioural model.
        do_reset();
        model_init();
        for (int i = 0; i < 3000; i++) begin
            int r;
            if ($urandom_range(0, 39) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 2) set_ops(4'b0000);
                else if (r < 8) set_ops(4'b0001 << $urandom_range(0, 3));
                else set_ops(4'($urandom));
            end
            cancel = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 29) == 0) water_Intake = !water_Intake;
            if ($urandom_range(0, ((i / 500) % 2 == 1) ? 2 : 24) == 0) level_sensor = !level_sensor;
            if ($urandom_range(0, 5) == 0) temp_sensor = !temp_sensor;
            @(posedge clock);
            model_step();
            @(negedge clock);
            check("rnd_secs", int'(seconds_Left), m_secs);
            check("rnd_wash", int'(wash), int'(m_wash));
            check("rnd_fault", int'(timer_Fault), int'(m_fault));
            check("rnd_fill", int'(fill_Water), int'(m_out[0]));
            check("rnd_heat", int'(heat_Water), int'(m_out[1]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
